// File: rtl/serial_to_parallel_framed_if.sv
// serial_to_parallel_framed_if: serial-in / parallel-out bus bundle for the framed receiver
interface serial_to_parallel_framed_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
);
    logic             i_enable;
    logic [CNT_W-1:0] i_framesize;
    logic             i_serial;
    logic             i_bit_valid;
    logic [WIDTH-1:0] o_parallel;
    logic             o_complete;
    logic             o_busy;
    logic             o_frame_error;
    logic             o_parity_error;
    modport master (
        output i_enable, i_framesize, i_serial, i_bit_valid,
        input  o_parallel, o_complete, o_busy, o_frame_error, o_parity_error
    );
    modport slave (
        input  i_enable, i_framesize, i_serial, i_bit_valid,
        output o_parallel, o_complete, o_busy, o_frame_error, o_parity_error
    );
endinterface

// File: rtl/serial_to_parallel_framed.sv
// serial_to_parallel_framed: assembles 1..WIDTH strobed serial bits into a right-justified word; STP_PARITY_CHECK_EN adds a trailing even-parity bit per frame
module serial_to_parallel_framed #(
    parameter int WIDTH     = 64,
    parameter int CNT_W     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    serial_to_parallel_framed_if.slave bus
);
`ifdef STP_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, r_fs, w_fs, w_pos;
    logic [WIDTH-1:0] r_shift, r_parallel, w_base, w_shift_nxt, w_word;
    logic             r_complete, r_busy, r_frame_error;
    logic             w_acc, w_bad, w_go, w_last, w_complete_nxt, w_ferr_nxt;
    assign w_acc       = bus.i_enable & bus.i_bit_valid;
    assign w_bad       = (r_state == IDLE) && (bus.i_framesize == '0 || bus.i_framesize > CNT_W'(WIDTH));
    assign w_go        = w_acc & ~w_bad;
    assign w_fs        = (r_state == IDLE) ? bus.i_framesize : r_fs;
    assign w_pos       = (r_state == IDLE) ? '0 : r_cnt;
    // With parity the data bits fill cnt 0..fs-1 and the bit arriving at cnt==fs is the parity bit.
    assign w_last      = PAR ? (r_state == SHIFT && r_cnt == r_fs) : (w_pos == w_fs - CNT_W'(1));
    assign w_base      = (r_state == IDLE) ? '0 : r_shift;
    assign w_shift_nxt = MSB_FIRST ? {w_base[WIDTH-2:0], bus.i_serial} : (w_base | (WIDTH'(bus.i_serial) << w_pos));
    assign w_word      = PAR ? r_shift : w_shift_nxt;
    // state register
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_state_nxt;
    // next state: every accepted good bit either finishes the frame or keeps assembling
    always_comb
        w_state_nxt = w_go ? (w_last ? IDLE : SHIFT) : r_state;
    // output decode for the registered pulses
    always_comb begin
        w_complete_nxt = w_go & w_last;
        w_ferr_nxt     = w_acc & w_bad;
    end
    // datapath: shift register, counter, latched frame size and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_fs          <= '0;
            r_parallel    <= '0;
            r_complete    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_complete    <= w_complete_nxt;
            r_frame_error <= w_ferr_nxt;
            r_busy        <= (w_state_nxt == SHIFT);
            if (w_go) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= w_last ? '0 : w_pos + CNT_W'(1);
                r_fs    <= w_fs;
            end
            if (w_complete_nxt)
                r_parallel <= w_word;
        end
    end
`ifdef STP_PARITY_CHECK_EN
    logic r_par, r_parity_error;
    // running XOR of data bits; the parity bit must bring it back to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par          <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            r_parity_error <= w_go & w_last & (r_par ^ bus.i_serial);
            if (w_go)
                r_par <= w_last ? 1'b0 : (((r_state == IDLE) ? 1'b0 : r_par) ^ bus.i_serial);
        end
    end
    assign bus.o_parity_error = r_parity_error;
`else
    assign bus.o_parity_error = 1'b0;
`endif
    assign bus.o_parallel    = r_parallel;
    assign bus.o_complete    = r_complete;
    assign bus.o_busy        = r_busy;
    assign bus.o_frame_error = r_frame_error;
endmodule

// File: tb/tb_serial_to_parallel_framed.sv
// tb_serial_to_parallel_framed: directed spec scenarios plus random traffic against a bit-queue reference model
module tb_serial_to_parallel_framed;
    localparam int W   = 64;
    localparam int CW  = 7;
    localparam bit MSB = 1'b1;
`ifdef STP_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    bit m_in;
    int m_fs;
    bit m_q[$];
    logic [W-1:0] e_parallel;
    logic e_complete, e_ferr, e_perr;
    serial_to_parallel_framed_if #(.WIDTH(W), .CNT_W(CW)) bus();
    serial_to_parallel_framed #(.WIDTH(W), .CNT_W(CW), .MSB_FIRST(MSB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic chk_all();
        chk("parallel", bus.o_parallel, e_parallel);
        chk("complete", W'(bus.o_complete), W'(e_complete));
        chk("busy", W'(bus.o_busy), W'(m_in));
        chk("frame_error", W'(bus.o_frame_error), W'(e_ferr));
        chk("parity_error", W'(bus.o_parity_error), W'(e_perr));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_bit_valid = 1'b1;
        bus.i_serial = 1'b1;
        bus.i_framesize = CW'(8);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_in = 1'b0;
        m_q.delete();
        e_parallel = '0;
        e_complete = 1'b0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        chk_all();
    endtask
    task automatic step(input bit en, input bit v, input bit s, input int fs);
        bit x;
        bus.i_enable = en;
        bus.i_bit_valid = v;
        bus.i_serial = s;
        bus.i_framesize = CW'(fs);
        @(posedge clk);
        #1;
        e_complete = 1'b0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        if (en && v) begin
            if (!m_in) begin
                if (fs == 0 || fs > W) e_ferr = 1'b1;
                else begin
                    m_in = 1'b1;
                    m_fs = fs;
                    m_q.delete();
                end
            end
            if (m_in) begin
                m_q.push_back(s);
                if (m_q.size() == m_fs + PAR) begin
                    e_parallel = '0;
                    for (int i = 0; i < m_fs; i++)
                        e_parallel[MSB ? m_fs - 1 - i : i] = m_q[i];
                    x = 1'b0;
                    foreach (m_q[i]) x ^= m_q[i];
                    e_perr = (PAR != 0) && x;
                    e_complete = 1'b1;
                    m_in = 1'b0;
                end
            end
        end
        chk_all();
    endtask
    task automatic send_frame(input logic [W-1:0] w, input int fs, input bit pbit);
        for (int i = 0; i < fs; i++) step(1'b1, 1'b1, w[fs-1-i], fs);
        if (PAR != 0) step(1'b1, 1'b1, pbit, fs);
    endtask
    initial begin
        logic [W-1:0] beef;
        int fsr;
        int r;
        int k;
        beef = 64'hBEEF;
        fsr = 8;
        bus.i_enable = 1'b0;
        bus.i_bit_valid = 1'b0;
        bus.i_serial = 1'b0;
        bus.i_framesize = '0;
        do_reset();
        send_frame(64'hF0F0F0F0F0F0F0F0, 64, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8);
        send_frame(64'hA5, 8, 1'b0);
        send_frame(64'h01, 8, 1'b1);
        send_frame(64'h3C, 8, 1'b0);
        send_frame(64'hC3, 8, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, beef[15-i], 16);
        repeat (5) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16);
        for (int i = 7; i < 16; i++) step(1'b1, 1'b1, beef[15-i], 3);
        if (PAR != 0) step(1'b1, 1'b1, ^beef, 5);
        step(1'b0, 1'b0, 1'b0, 8);
        for (int i = 0; i < 29; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 64);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 8);
        send_frame(64'h5A, 8, 1'b0);
        step(1'b1, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 65);
        step(1'b0, 1'b0, 1'b0, 8);
`ifdef STP_PARITY_CHECK_EN
        send_frame(64'hA5, 8, 1'b0);
        send_frame(64'hA5, 8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8);
`endif
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) do_reset();
            else begin
                if (!m_in || $urandom_range(0, 9) == 0) begin
                    k = $urandom_range(0, 19);
                    fsr = (k == 0) ? 0 : (k == 1) ? 65 : (k < 6) ? $urandom_range(1, 64) : $urandom_range(1, 8);
                end
                step(r >= 12, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), fsr);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
